vote_collector: RTL and testbench

VOTE_COLLECTOR -- requirements
Module: vote_collector

---
 rtl/vote_collector.sv | 141 ++++++++++++++
 tb/tb_vote_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vote_collector.sv
// vote_collector: gathers one vote from each of four members into a ballot
// and holds it for a downstream tally stage until that stage acknowledges it.
// A round closes when all four members have voted or when the timeout expires.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           opens a round (honoured only in IDLE)
//   vote_valid      a vote is offered this cycle
//   voter_id        member index 0..3 of the offered vote
//   vote_val        1 = yes, 0 = no
//   ack             downstream has consumed the held ballot
//   ballot          bit i = vote of member i (absent member reads as no)
//   ballot_valid    ballot is complete and stable (HOLD)
//   voted_mask      bit i = member i has voted this round
//   busy            high in COLLECT and HOLD
//   dup_err         one-cycle pulse after a rejected repeat vote
//   timed_out       the current ballot was closed by the timeout
module vote_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       vote_valid,
  input  logic [1:0] voter_id,
  input  logic       vote_val,
  input  logic       ack,
  output logic [3:0] ballot,
  output logic       ballot_valid,
  output logic [3:0] voted_mask,
  output logic       busy,
  output logic       dup_err,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Timer value seen on the last COLLECT cycle before a forced close.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] ballot_q, ballot_d;
  logic [3:0] mask_q, mask_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       dup_q, dup_d;
  logic       to_q, to_d;
  logic [3:0] vote_sel;

  assign vote_sel = 4'b0001 << voter_id;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ballot_d = ballot_q;
    mask_d   = mask_q;
    to_d     = to_q;
    dup_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          timer_d  = 8'd0;
          ballot_d = 4'b0000;
          mask_d   = 4'b0000;
          to_d     = 1'b0;
        end
      end

      COLLECT: begin
        if (vote_valid) begin
          if ((mask_q & vote_sel) != 4'b0000) begin
            dup_d = 1'b1;
          end else begin
            mask_d   = mask_q | vote_sel;
            ballot_d = vote_val ? (ballot_q | vote_sel) : (ballot_q & ~vote_sel);
          end
        end
        // A full mask wins over the timeout so a last-cycle final vote
        // still produces a complete, non-timed-out ballot.
        if (mask_d == 4'b1111) begin
          state_d = HOLD;
          to_d    = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = HOLD;
          to_d    = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      HOLD: begin
        if (ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= 8'd0;
      ballot_q <= 4'b0000;
      mask_q   <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dup_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ballot_q <= ballot_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dup_q    <= dup_d;
      to_q     <= to_d;
    end
  end

  assign ballot       = ballot_q;
  assign ballot_valid = valid_q;
  assign voted_mask   = mask_q;
  assign busy         = busy_q;
  assign dup_err      = dup_q;
  assign timed_out    = to_q;

endmodule

// File: tb/tb_vote_collector.sv
// Testbench for vote_collector: directed rounds checked both against
// hand-computed literals and, every cycle, against a round-level model.
module tb_vote_collector;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vote_valid = 1'b0;
  logic [1:0] voter_id = 2'd0;
  logic       vote_val = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic [3:0] voted_mask;
  logic       busy;
  logic       dup_err;
  logic       timed_out;

  always #5 clk = ~clk;

  vote_collector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid),
    .voter_id(voter_id), .vote_val(vote_val), .ack(ack),
    .ballot(ballot), .ballot_valid(ballot_valid), .voted_mask(voted_mask),
    .busy(busy), .dup_err(dup_err), .timed_out(timed_out)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Round-level model: is a round open, is a ballot being held, who has
  // voted and how, how many collect cycles have elapsed.
  bit m_open = 1'b0;
  bit m_done = 1'b0;
  bit m_dup  = 1'b0;
  bit m_to   = 1'b0;
  bit m_has[4];
  bit m_yes[4];
  int m_cyc = 0;

  function automatic logic [3:0] pack(input bit a[4]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step();
    int n;
    if (rst) begin
      m_open = 0; m_done = 0; m_dup = 0; m_to = 0; m_cyc = 0;
      for (int i = 0; i < 4; i++) begin m_has[i] = 0; m_yes[i] = 0; end
    end else if (m_open) begin
      m_dup = 0;
      if (vote_valid) begin
        if (m_has[voter_id]) m_dup = 1;
        else begin
          m_has[voter_id] = 1;
          m_yes[voter_id] = vote_val;
        end
      end
      m_cyc++;
      n = 0;
      for (int i = 0; i < 4; i++) n += int'(m_has[i]);
      if (n == 4) begin
        m_open = 0; m_done = 1; m_to = 0;
      end else if (m_cyc == TO) begin
        m_open = 0; m_done = 1; m_to = 1;
      end
    end else if (m_done) begin
      m_dup = 0;
      if (ack) m_done = 0;
    end else begin
      m_dup = 0;
      if (start) begin
        m_open = 1; m_cyc = 0; m_to = 0;
        for (int i = 0; i < 4; i++) begin m_has[i] = 0; m_yes[i] = 0; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic s, input logic vv, input logic [1:0] id,
                       input logic val, input logic a);
    start = s; vote_valid = vv; voter_id = id; vote_val = val; ack = a;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'd0, 0, 0);
  endtask

  task automatic vote(input logic [1:0] id, input logic val);
    drive(0, 1, id, val, 0);
  endtask

  logic [11:0] dut_vec, mdl_vec;
  assign dut_vec = {ballot, ballot_valid, voted_mask, busy, dup_err, timed_out};
  assign mdl_vec = {pack(m_yes), m_done, pack(m_has), m_open | m_done, m_dup, m_to};

  initial begin
    for (int i = 0; i < 4; i++) begin m_has[i] = 0; m_yes[i] = 0; end

    fork
      forever begin
        @(negedge clk);
        if (cmp_en) chk("cycle_model", 32'(dut_vec), 32'(mdl_vec));
      end
    join_none

    // Reset with start/vote/ack all asserted: reset must win.
    start = 1; vote_valid = 1; ack = 1;
    tick();
    tick();
    cmp_en = 1'b1;
    chk("reset_state", 32'(dut_vec), 32'h0);
    rst = 0;
    idle(1);

    // Full round, consecutive votes.
    drive(1, 0, 2'd0, 0, 0);
    chk("round_busy", 32'(busy), 32'h1);
    vote(2'd0, 1); vote(2'd1, 0); vote(2'd2, 1);
    chk("round_not_yet_valid", 32'(ballot_valid), 32'h0);
    vote(2'd3, 1);
    chk("round_ballot", 32'(ballot), 32'hd);
    chk("round_valid", 32'(ballot_valid), 32'h1);
    chk("round_timed_out", 32'(timed_out), 32'h0);
    drive(0, 0, 2'd0, 0, 1);
    chk("round_after_ack", 32'({busy, ballot_valid, ballot}), 32'h00d);
    idle(2);

    // Duplicate vote.
    drive(1, 0, 2'd0, 0, 0);
    vote(2'd2, 1);
    vote(2'd2, 0);
    chk("dup_pulse", 32'(dup_err), 32'h1);
    chk("dup_ballot", 32'(ballot), 32'h4);
    chk("dup_mask", 32'(voted_mask), 32'h4);
    idle(1);
    chk("dup_one_cycle", 32'(dup_err), 32'h0);
    for (int i = 0; i < 40 && !ballot_valid; i++) idle(1);
    chk("dup_round_close", 32'(ballot_valid), 32'h1);
    chk("dup_round_to", 32'(timed_out), 32'h1);
    drive(0, 0, 2'd0, 0, 1);
    idle(1);

    // Timeout with two votes; start mid-collect must not restart the timer.
    drive(1, 0, 2'd0, 0, 0);
    vote(2'd1, 1); vote(2'd3, 1);
    drive(1, 0, 2'd0, 0, 0);
    idle(12);
    chk("to_still_collect", 32'({busy, ballot_valid}), 32'h2);
    idle(1);
    chk("to_valid", 32'(ballot_valid), 32'h1);
    chk("to_flag", 32'(timed_out), 32'h1);
    chk("to_ballot", 32'(ballot), 32'ha);
    chk("to_mask", 32'(voted_mask), 32'ha);
    drive(0, 0, 2'd0, 0, 1);
    idle(1);

    // Fourth vote on the last timer cycle, then start coincident with ack.
    drive(1, 0, 2'd0, 0, 0);
    vote(2'd0, 1); vote(2'd1, 1); vote(2'd2, 0);
    idle(12);
    vote(2'd3, 0);
    chk("coin_valid", 32'(ballot_valid), 32'h1);
    chk("coin_to", 32'(timed_out), 32'h0);
    chk("coin_ballot", 32'(ballot), 32'h3);
    drive(1, 0, 2'd0, 0, 1);
    chk("coin_start_ack", 32'({busy, ballot_valid}), 32'h0);
    idle(1);
    chk("coin_no_new_round", 32'(busy), 32'h0);

    // Reset mid-collect.
    drive(1, 0, 2'd0, 0, 0);
    vote(2'd0, 1); vote(2'd1, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_outputs", 32'(dut_vec), 32'h0);
    vote(2'd2, 1);
    chk("rst_vote_ignored", 32'({voted_mask, dup_err, busy}), 32'h0);

    // Ballot held across 20 cycles of vote noise, then reset in HOLD.
    drive(1, 0, 2'd0, 0, 0);
    vote(2'd0, 0); vote(2'd1, 1); vote(2'd2, 0); vote(2'd3, 1);
    for (int i = 0; i < 20; i++) drive(0, logic'(i % 2), 2'(i), logic'(i / 3 % 2), 0);
    chk("hold_ballot", 32'(ballot), 32'ha);
    chk("hold_mask", 32'(voted_mask), 32'hf);
    chk("hold_valid", 32'({ballot_valid, dup_err}), 32'h2);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_in_hold", 32'({ballot_valid, busy, ballot}), 32'h0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
